// File: rtl/countdown_timer.sv
// countdown_timer
//
// Loadable down-counter with a terminal-count pulse. A load captures
// load_val. A non-zero value starts a countdown. While running, each
// cycle with en=1 decrements the count by one. Reaching zero gives a
// one-cycle done pulse.
//
// Build option COUNTDOWN_AUTO_RELOAD_EN:
//   undefined : one-shot. The timer returns to IDLE after the terminal
//               decrement.
//   defined   : periodic. The terminal decrement reloads the last loaded
//               value and the timer stays in RUN.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   load      in   load request; takes priority over en
//   load_val  in   [WIDTH-1:0] start value
//   en        in   decrement enable, used only in RUN
//   count     out  [WIDTH-1:0] registered counter value
//   busy      out  registered, high in RUN
//   done      out  registered, one-cycle pulse after a terminal decrement
//   zero      out  combinational, count == 0
//
// State | meaning
// IDLE  | not counting; en ignored; busy=0
// RUN   | counting down on en; busy=1

module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q,  done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            // A load also wins over a coinciding terminal decrement, so
            // no done pulse is produced in that case.
            count_d = load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_d = load_val;
`endif
            state_d = (load_val != '0) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q == ONE) begin
                done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                count_d = reload_q;
                state_d = RUN;
`else
                count_d = '0;
                state_d = IDLE;
`endif
            end else if (count_q == '0) begin
                // RUN with a zero count is unreachable. Drop back to IDLE
                // without a pulse, and never wrap.
                state_d = IDLE;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign zero  = (count_q == '0);

endmodule
